// File: rtl/cal_core_feeder_pkg.sv
// cal_core_feeder_pkg: shared FSM encoding and width helpers for the cal_core blocks
package cal_core_feeder_pkg;
  typedef enum logic [1:0] {IDLE, SEND_H, SEND_ALPHA, WAIT_BETA} state_t;
  localparam int J_DEF = 14;
  localparam int I_DEF = 7;
  localparam int A_DEF = 2;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int addr_w(input int i, input int a);
    return $clog2(i > a ? i : a) + 1;
  endfunction
  localparam int ADDR_W_DEF = addr_w(I_DEF, A_DEF);
endpackage

// File: rtl/cal_core_feeder_if.sv
// cal_core_feeder_if: H row / alpha column stream to the core and beta result back
interface cal_core_feeder_if #(parameter int J = 14, parameter int A = 2);
  logic [J-1:0] H_row;
  logic H_row_tvalid;
  logic [J*8-1:0] alpha_u_col;
  logic alpha_u_col_tvalid;
  logic alpha_u_col_tlast;
  logic [A*8-1:0] beta;
  logic beta_tvalid;
  modport master(output H_row, H_row_tvalid, alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
                 input beta, beta_tvalid);
  modport slave(input H_row, H_row_tvalid, alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
                output beta, beta_tvalid);
endinterface

// File: rtl/cal_core_feeder_buf.sv
// feeder_buf: H row buffer and alpha column buffer, one write port, two combinational reads
module feeder_buf
  import cal_core_feeder_pkg::*;
#(
  parameter int J = J_DEF,
  parameter int I = I_DEF,
  parameter int A = A_DEF,
  localparam int AW = addr_w(I, A),
  localparam int HW = cw(I),
  localparam int CWD = cw(A)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic           sel,
  input  logic [AW-1:0]  addr,
  input  logic [J*8-1:0] data,
  input  logic [HW-1:0]  h_addr,
  output logic [J-1:0]   h_data,
  input  logic [CWD-1:0] a_addr,
  output logic [J*8-1:0] a_data
);
  logic [J-1:0] hbuf [I];
  logic [J*8-1:0] abuf [A];
  // writes land only on in-range entries of the selected buffer; reset clears both
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < I; k++) hbuf[k] <= '0;
      for (int k = 0; k < A; k++) abuf[k] <= '0;
    end else if (we && !sel && addr < AW'(I)) hbuf[addr[HW-1:0]] <= data[J-1:0];
    else if (we && sel && addr < AW'(A)) abuf[addr[CWD-1:0]] <= data;
  assign h_data = hbuf[h_addr];
  assign a_data = abuf[a_addr];
endmodule

// File: rtl/cal_core_feeder.sv
// cal_core_feeder: streams each H row and the alpha columns to the core and collects beta per row
module cal_core_feeder
  import cal_core_feeder_pkg::*;
#(
  parameter int J = J_DEF,
  parameter int I = I_DEF,
  parameter int A = A_DEF,
  localparam int AW = addr_w(I, A)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [AW-1:0]        wr_addr,
  input  logic [J*8-1:0]       wr_data,
  input  logic                 start,
  cal_core_feeder_if.master    core,
  output logic [I*A*8-1:0]     beta_all,
  output logic                 busy,
  output logic                 done
);
  localparam int RW = cw(I);
  localparam int CWD = cw(A);
  localparam int BW = A * 8;
  state_t state, state_nx;
  logic [RW-1:0] r;
  logic [CWD-1:0] c;
  logic [J-1:0] h_data;
  logic [J*8-1:0] a_data;
  logic last_col, last_row, capture;
  assign last_col = c == CWD'(A - 1);
  assign last_row = r == RW'(I - 1);
  assign capture = state == WAIT_BETA && core.beta_tvalid;
  feeder_buf #(.J(J), .I(I), .A(A)) u_buf (
    .clk, .rst,
    .we(wr_en && state == IDLE), .sel(wr_sel), .addr(wr_addr), .data(wr_data),
    .h_addr(r), .h_data,
    .a_addr(c), .a_data
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: one H cycle, A alpha cycles, then hold until the core answers
  always_comb
    state_nx = state == IDLE       ? (start ? SEND_H : IDLE) :
               state == SEND_H     ? SEND_ALPHA :
               state == SEND_ALPHA ? (last_col ? WAIT_BETA : SEND_ALPHA) :
               capture             ? (last_row ? IDLE : SEND_H) : WAIT_BETA;
  // stream outputs decoded from state, data forced to 0 when not valid
  always_comb begin
    core.H_row_tvalid = state == SEND_H;
    core.H_row = state == SEND_H ? h_data : '0;
    core.alpha_u_col_tvalid = state == SEND_ALPHA;
    core.alpha_u_col = state == SEND_ALPHA ? a_data : '0;
    core.alpha_u_col_tlast = state == SEND_ALPHA && last_col;
    busy = state != IDLE;
  end
  // row/column counters, beta capture and the end-of-job pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r <= '0;
      c <= '0;
      beta_all <= '0;
      done <= 1'b0;
    end else begin
      done <= capture && last_row;
      if (state == SEND_H) c <= '0;
      if (state == SEND_ALPHA) c <= last_col ? '0 : c + 1'b1;
      if (capture) begin
        beta_all[r*BW +: BW] <= core.beta;
        r <= last_row ? '0 : r + 1'b1;
      end
    end
endmodule

// File: tb/tb_cal_core_feeder.sv
// tb_cal_core_feeder: directed stimulus, pass-level reference model and per-cycle compare
module tb_cal_core_feeder;
  import cal_core_feeder_pkg::*;
  localparam int J = 14, I = 7, A = 2, BW = A * 8, AW = addr_w(I, A);
  localparam int J1 = 4, I1 = 2, A1 = 1, AW1 = addr_w(I1, A1);
  logic clk = 0, rst = 1, wr_en = 0, wr_sel = 0, start = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [J*8-1:0] wr_data = '0;
  logic [I*A*8-1:0] beta_all;
  logic busy, done;
  logic wr_en1 = 0, wr_sel1 = 0, start1 = 0;
  logic [AW1-1:0] wr_addr1 = '0;
  logic [J1*8-1:0] wr_data1 = '0;
  logic [I1*A1*8-1:0] beta_all1;
  logic busy1, done1;
  cal_core_feeder_if #(.J(J), .A(A)) core();
  cal_core_feeder_if #(.J(J1), .A(A1)) core1();
  cal_core_feeder #(.J(J), .I(I), .A(A)) dut (
    .clk, .rst, .wr_en, .wr_sel, .wr_addr, .wr_data, .start,
    .core(core.master), .beta_all, .busy, .done
  );
  cal_core_feeder #(.J(J1), .I(I1), .A(A1)) dut1 (
    .clk, .rst, .wr_en(wr_en1), .wr_sel(wr_sel1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .start(start1), .core(core1.master), .beta_all(beta_all1), .busy(busy1), .done(done1)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, done_cnt = 0, cd = 0, rowc = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  logic [J-1:0] hb [I];
  logic [J*8-1:0] ab [A];
  logic [BW-1:0] eb [I];
  bit m_act, m_done;
  int m_pos, m_row;
  logic [I*A*8-1:0] eb_flat;
  logic [J*8-1:0] exp_a;
  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_done = 0; m_pos = 0; m_row = 0;
      for (int k = 0; k < I; k++) begin hb[k] = '0; eb[k] = '0; end
      for (int k = 0; k < A; k++) ab[k] = '0;
    end else begin
      m_done = 0;
      if (!m_act) begin
        if (wr_en && !wr_sel && int'(wr_addr) < I) hb[int'(wr_addr)] = wr_data[J-1:0];
        if (wr_en && wr_sel && int'(wr_addr) < A) ab[int'(wr_addr)] = wr_data;
        if (start) begin m_act = 1; m_row = 0; m_pos = 0; end
      end else if (m_pos <= A) m_pos++;
      else if (core.beta_tvalid) begin
        eb[m_row] = core.beta;
        if (m_row == I - 1) begin m_act = 0; m_done = 1; end
        else begin m_row++; m_pos = 0; end
      end
    end
    #1;
    for (int k = 0; k < I; k++) eb_flat[k*BW +: BW] = eb[k];
    exp_a = '0;
    if (m_act && m_pos >= 1 && m_pos <= A) exp_a = ab[m_pos-1];
    check("m_h_valid", core.H_row_tvalid, m_act && m_pos == 0);
    check("m_h_row", core.H_row, (m_act && m_pos == 0) ? hb[m_row] : '0);
    check("m_a_valid", core.alpha_u_col_tvalid, m_act && m_pos >= 1 && m_pos <= A);
    check("m_a_col", core.alpha_u_col, exp_a);
    check("m_a_tlast", core.alpha_u_col_tlast, m_act && m_pos == A);
    check("m_busy", busy, m_act);
    check("m_done", done, m_done);
    check("m_beta_all", beta_all, eb_flat);
    if (done === 1'b1) done_cnt++;
  end
  task automatic step();
    @(negedge clk);
    start = 0; wr_en = 0; core.beta_tvalid = 0; core.beta = '0;
    if (core.alpha_u_col_tlast) cd = 5;
    else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        core.beta = {rowc[7:0], rowc[7:0]};
        core.beta_tvalid = 1;
        rowc++;
      end
    end
  endtask
  task automatic wr(input logic sel, input int addr, input logic [J*8-1:0] data);
    wr_en = 1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
    step();
  endtask
  task automatic run_until_idle(input bit inj, input bit start_on_last);
    for (int n = 0; n < 200 && busy; n++) begin
      step();
      if (inj && core.H_row_tvalid && rowc == 1) begin core.beta = '1; core.beta_tvalid = 1; end
      if (start_on_last && core.beta_tvalid && rowc == I) start = 1;
    end
    check("job_finished", busy, 0);
  endtask
  logic [I*A*8-1:0] exp_all;
  int dc;
  initial begin
    core.beta = '0; core.beta_tvalid = 0; core1.beta = '0; core1.beta_tvalid = 0;
    for (int i = 0; i < I; i++) exp_all[i*BW +: BW] = {i[7:0], i[7:0]};
    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_h_valid", core.H_row_tvalid, 0);
    check("rst_beta_all", beta_all, 0);
    check("rst_busy1", busy1, 0);
    rst = 0;
    step();
    core.beta = '1; core.beta_tvalid = 1;
    step();
    check("idle_beta_ignored", beta_all, 0);
    for (int i = 0; i < I; i++) wr(0, i, (J*8)'(1) << i);
    wr(1, 0, {J{8'h11}});
    wr(1, 1, {J{8'h22}});
    wr(0, 7, '1);
    wr(1, 2, '1);
    rowc = 0; cd = 0; start = 1;
    step();
    check("job1_h_valid_c1", core.H_row_tvalid, 1);
    check("job1_h_row_c1", core.H_row, 14'h0001);
    step();
    check("job1_a0", core.alpha_u_col, {J{8'h11}});
    check("job1_tlast_c2", core.alpha_u_col_tlast, 0);
    start = 1;
    step();
    check("job1_a1", core.alpha_u_col, {J{8'h22}});
    check("job1_tlast_c3", core.alpha_u_col_tlast, 1);
    step();
    wr_en = 1; wr_sel = 0; wr_addr = '0; wr_data = '1;
    run_until_idle(1, 0);
    check("job1_done_now", done, 1);
    check("job1_done_cnt", done_cnt, 1);
    check("job1_beta_all", beta_all, exp_all);
    step();
    check("done_one_cycle", done, 0);
    rowc = 0; cd = 0; start = 1;
    step();
    check("job2_h0_unchanged", core.H_row, 14'h0001);
    step();
    check("job2_a0_unchanged", core.alpha_u_col, {J{8'h11}});
    run_until_idle(0, 1);
    step();
    step();
    check("start_on_last_ignored", busy, 0);
    check("job2_done_cnt", done_cnt, 2);
    rowc = 0; cd = 0;
    wr_en = 1; wr_sel = 0; wr_addr = '0; wr_data = 14'h2AAA; start = 1;
    step();
    check("wr_start_same_cycle", core.H_row, 14'h2AAA);
    for (int n = 0; n < 100 && !(rowc == 3 && cd > 0); n++) step();
    step();
    dc = done_cnt;
    rst = 1; cd = 0;
    #1;
    check("rst_mid_h_valid", core.H_row_tvalid, 0);
    check("rst_mid_a_valid", core.alpha_u_col_tvalid, 0);
    check("rst_mid_tlast", core.alpha_u_col_tlast, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_beta_all", beta_all, 0);
    step();
    step();
    rst = 0; cd = 0; rowc = 0;
    check("rst_no_done", done_cnt, dc);
    start = 1;
    step();
    check("replay_h_valid", core.H_row_tvalid, 1);
    check("replay_h_zero", core.H_row, 0);
    step();
    check("replay_a_valid", core.alpha_u_col_tvalid, 1);
    check("replay_a_zero", core.alpha_u_col, 0);
    run_until_idle(0, 0);
    check("replay_beta_all", beta_all, exp_all);
    wr_en1 = 1; wr_sel1 = 1; wr_addr1 = '0; wr_data1 = 32'h12345678;
    step();
    wr_sel1 = 0; wr_data1 = 32'h5;
    step();
    wr_en1 = 0; start1 = 1;
    step();
    start1 = 0;
    check("a1_h_valid", core1.H_row_tvalid, 1);
    check("a1_h_row", core1.H_row, 4'h5);
    step();
    check("a1_a_valid", core1.alpha_u_col_tvalid, 1);
    check("a1_a_col", core1.alpha_u_col, 32'h12345678);
    check("a1_tlast", core1.alpha_u_col_tlast, 1);
    step();
    check("a1_wait_no_valid", core1.alpha_u_col_tvalid, 0);
    check("a1_wait_busy", busy1, 1);
    core1.beta = 8'hA5; core1.beta_tvalid = 1;
    step();
    core1.beta_tvalid = 0;
    check("a1_beta_all", beta_all1, 16'h00A5);
    check("a1_next_row_h", core1.H_row_tvalid, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cal_core_feeder.md
CAL_CORE_FEEDER -- requirements
Module: cal_core_feeder

Interface
REQ-001 Parameter J, default 14, number of variable nodes (H_row width, alpha column depth).
REQ-002 Parameter I, default 7, number of H rows per job.
REQ-003 Parameter A, default 2, number of alpha columns per row pass; beta width A*8.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset: clk is the clock and rst is the asynchronous active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 wr_en  in  1  buffer write strobe.
REQ-008 wr_sel  in  1  0 = H buffer, 1 = alpha buffer.
REQ-009 wr_addr  in  clog2(max(I,A))+1  entry index.
REQ-010 wr_data  in  J*8  write data; H writes use bits [J-1:0].
REQ-011 start  in  1  single-cycle job start pulse.
REQ-012 H_row / H_row_tvalid  out  J / 1  H row to the core.
REQ-013 alpha_u_col / alpha_u_col_tvalid / alpha_u_col_tlast  out  J*8 / 1 / 1  alpha column stream to the core.
REQ-014 beta / beta_tvalid  in  A*8 / 1  result from the core.
REQ-015 beta_all  out  I*A*8  collected results, row i at bits [i*A*8 +: A*8].
REQ-016 busy  out  1  job in progress; done  out  1  one-cycle end-of-job pulse.

Function
REQ-017 FSM states IDLE, SEND_H, SEND_ALPHA, WAIT_BETA; reset state IDLE.
REQ-018 IDLE: start=1 -> SEND_H, row index r=0, busy=1 next cycle.
REQ-019 SEND_H: for one cycle, H_row=Hbuf[r] and H_row_tvalid=1; then SEND_ALPHA with column counter c=0.
REQ-020 SEND_ALPHA: each cycle, alpha_u_col=Abuf[c] and alpha_u_col_tvalid=1; tlast=1 only when c==A-1; after c==A-1 -> WAIT_BETA.
REQ-021 Timing: start at cycle 0 -> H_row_tvalid at cycle 1, alpha columns at cycles 2..A+1; no backpressure and no idle cycles inside a pass.
REQ-022 WAIT_BETA: first beta_tvalid stores beta into beta_all row r; if r==I-1 -> IDLE with done=1 the same cycle and busy=0; else r+1 -> SEND_H the next cycle.
REQ-023 beta_tvalid outside WAIT_BETA SHALL be ignored, with no effect on beta_all.
REQ-024 start while busy SHALL be ignored.
REQ-025 wr_en while busy SHALL be ignored; wr_en in IDLE writes the selected entry the next edge; out-of-range wr_addr (>=I for H, >=A for alpha) SHALL be ignored.
REQ-026 wr_en and start in the same IDLE cycle: the write completes and the job uses the new value.
REQ-027 beta_tvalid coincident with the last-row capture and start in the same cycle: the start is ignored, because busy is still 1 in that cycle.
REQ-028 Data outputs SHALL drive 0 whenever their tvalid is 0.

Reset
REQ-029 rst asserted SHALL force, immediately and asynchronously, state=IDLE, r=c=0, all tvalid/tlast=0, busy=0, done=0, beta_all=0, and Hbuf and Abuf cleared to 0.
REQ-030 rst asserted mid-job SHALL abort the job with no done pulse; a new job requires a fresh start after rst deasserts.

Structure
REQ-031 FSM state encodings and the clog2-derived width constants SHALL reside in the shared package used by the cal_core blocks.
REQ-032 Hbuf (I x J) and Abuf (A x J*8) SHALL be one sub-module, feeder_buf, with a write port and two combinational read ports.

Verification
REQ-033 Load Hbuf[0..6]=0x0001<<i and Abuf[0]=all 0x11, Abuf[1]=all 0x22; start -> H_row=0x0001 at cycle 1; alpha cols 0x11.., 0x22.. at cycles 2-3; tlast at cycle 3 only.
REQ-034 Full job, with beta returned 5 cycles after each tlast as {row,row} -> 7 passes, done pulses once, beta_all row i = {i,i}, busy=0 after done.
REQ-035 start pulsed during SEND_ALPHA and wr_en during WAIT_BETA -> no stream restart, buffer contents unchanged.
REQ-036 beta_tvalid=1 in IDLE and in SEND_H with beta=0xFFFF -> beta_all unchanged.
REQ-037 rst asserted in WAIT_BETA of row 3 -> all outputs 0 immediately, no done; a following start replays from row 0 using zeroed buffers.
REQ-038 A=1 build: single column with tlast=1 at cycle 2 -> WAIT_BETA entered correctly.
